// File: rtl/jr_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jr_hazard_ctrl
//  Purpose  : ID-stage jump-register (JR/JALR) resolution controller for a
//             5-stage MIPS pipeline. Compares the JR source register against
//             in-flight writers in EX and MEM, selects the ID-stage forwarding
//             source, stalls the front end while a load result is not yet
//             forwardable, then issues a one-cycle redirect strobe and flushes
//             the wrong-path fetch. Counts JR stall cycles (saturating).
//  Ports    : clk_i, reset_n_i (sync, active-low)
//             id_valid_i, id_is_jr_i, id_rs_addr_i       - ID-stage JR request
//             ex_reg_write_i, ex_mem_read_i, ex_rd_addr_i    - EX producer
//             mem_reg_write_i, mem_mem_read_i, mem_rd_addr_i - MEM producer
//             ext_stall_i                                - global freeze
//             fwd_sel_o (00 RF, 01 EX, 10 MEM), stall_front_o, jr_take_o,
//             flush_ifid_o, busy_o, stall_count_o
//  Revision : 1.0 - initial release
// ============================================================================
module jr_hazard_ctrl #(
    parameter int FLUSH_SLOTS = 1,   // 1..3 cycles of flush after a redirect
    parameter int CNT_W       = 16   // stall performance counter width
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             id_valid_i,
    input  logic             id_is_jr_i,
    input  logic [4:0]       id_rs_addr_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             mem_reg_write_i,
    input  logic             mem_mem_read_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic             ext_stall_i,
    output logic [1:0]       fwd_sel_o,
    output logic             stall_front_o,
    output logic             jr_take_o,
    output logic             flush_ifid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]       C_FLUSH_LOAD = 2'(FLUSH_SLOTS);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       ctr_q, ctr_d;
    logic [CNT_W-1:0] stall_count_q;

    logic             w_jr_req;
    logic             w_ex_hit;
    logic             w_mem_hit;
    logic             w_ex_load;
    logic             w_mem_load;

    logic [1:0]       w_fwd_sel;
    logic             w_stall_front;
    logic             w_jr_take;
    logic             w_flush_ifid;

    assign w_jr_req  = id_valid_i & id_is_jr_i;
    assign w_ex_hit  = ex_reg_write_i  & (ex_rd_addr_i  != 5'd0) & (ex_rd_addr_i  == id_rs_addr_i);
    assign w_mem_hit = mem_reg_write_i & (mem_rd_addr_i != 5'd0) & (mem_rd_addr_i == id_rs_addr_i);

    // An EX hit shadows any MEM hit: the EX instruction holds the youngest
    // value of rs, so a load sitting in MEM behind an ALU writer in EX is
    // irrelevant and must not cause a stall.
    assign w_ex_load  = w_ex_hit & ex_mem_read_i;
    assign w_mem_load = ~w_ex_hit & w_mem_hit & mem_mem_read_i;

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        w_fwd_sel     = 2'b00;
        w_stall_front = 1'b0;
        w_jr_take     = 1'b0;
        w_flush_ifid  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (w_jr_req) begin
                    if (w_ex_load) begin
                        // Two bubbles: this cycle plus one in STALL.
                        w_stall_front = 1'b1;
                        ctr_d         = 2'd1;
                        state_d       = ST_STALL;
                    end else if (w_mem_load) begin
                        // Single bubble: stay in IDLE and re-evaluate once
                        // the load has moved on to WB.
                        w_stall_front = 1'b1;
                        ctr_d         = 2'd0;
                    end else begin
                        w_jr_take = 1'b1;
                        if (w_ex_hit) begin
                            w_fwd_sel = 2'b01;
                        end else if (w_mem_hit) begin
                            w_fwd_sel = 2'b10;
                        end
                        ctr_d   = C_FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_STALL: begin
                w_stall_front = 1'b1;
                ctr_d         = ctr_q - 2'd1;
                if (ctr_q <= 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Any JR seen here is on the wrong path and is ignored.
                w_flush_ifid = 1'b1;
                ctr_d        = ctr_q - 2'd1;
                if (ctr_q <= 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = 2'd0;
            end
        endcase

        // Global freeze: hold all sequencing state and suppress the
        // single-shot strobes so they fire once the pipeline moves again.
        if (ext_stall_i) begin
            state_d      = state_q;
            ctr_d        = ctr_q;
            w_jr_take    = 1'b0;
            w_flush_ifid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            ctr_q         <= 2'd0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            if (w_stall_front && !ext_stall_i && (stall_count_q != C_CNT_MAX)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    // Outputs are held quiet while reset is asserted, even though the
    // request decode above still sees live pipeline inputs.
    assign fwd_sel_o     = reset_n_i ? w_fwd_sel : 2'b00;
    assign stall_front_o = reset_n_i & w_stall_front;
    assign jr_take_o     = reset_n_i & w_jr_take;
    assign flush_ifid_o  = reset_n_i & w_flush_ifid;
    assign busy_o        = reset_n_i & (state_q != ST_IDLE);
    assign stall_count_o = reset_n_i ? stall_count_q : '0;

endmodule
`default_nettype wire

// File: doc/jr_hazard_ctrl.md
Name: jr_hazard_ctrl

Overview:
- Sequencing controller for jump-register (JR/JALR) resolution in the ID stage of the 5-stage MIPS pipeline.
- Checks the JR source register against in-flight writers in EX and MEM, and selects the forwarding source for the ID-stage forwarding mux.
- Stalls the front end when the value is not yet forwardable (load in flight), then issues the redirect and flushes wrong-path fetches.
- Keeps a saturating count of JR stall cycles for performance monitoring.

Parameters:
- FLUSH_SLOTS, 1, cycles flush_ifid is held after a redirect (1..3).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  ID-stage instruction is valid
- id_is_jr  in  1  ID instruction is JR/JALR
- id_rs_addr  in  5  JR source register
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is a load
- ex_rd_addr  in  5  EX destination
- mem_reg_write  in  1  MEM instruction writes the register file
- mem_mem_read  in  1  MEM instruction is a load
- mem_rd_addr  in  5  MEM destination
- ext_stall  in  1  global pipeline freeze (cache miss)
- fwd_sel  out  2  00 regfile, 01 EX result, 10 MEM result
- stall_front  out  1  hold PC and IF/ID, insert bubble into ID/EX
- jr_take  out  1  one-cycle redirect strobe: PC <= forwarded rs value
- flush_ifid  out  1  squash IF/ID contents
- busy  out  1  FSM not in IDLE
- stall_count  out  CNT_W  saturating count of cycles stall_front was high

Behaviour:
- States: IDLE, STALL, FLUSH. Reset (reset_n low at a clk edge): state IDLE, counters 0. All outputs 0 while in reset and after it.
- jr_req = id_valid & id_is_jr.
- ex_hit = ex_reg_write & (ex_rd_addr != 0) & (ex_rd_addr == id_rs_addr). mem_hit is defined the same way for MEM.
- Register 0 never matches, so fwd_sel is 00 for rs = 0.
- Priority: EX over MEM over regfile.
- Required stall count N (evaluated in IDLE with jr_req):
  - ex_hit & ex_mem_read: N = 2.
  - else mem_hit & mem_mem_read: N = 1.
  - else N = 0.
  - An ALU producer in EX or MEM needs no stall.
- IDLE, jr_req, N = 0:
  - fwd_sel = 01 on ex_hit, else 10 on mem_hit, else 00.
  - jr_take = 1, combinational, same cycle.
  - Next state FLUSH, flush counter loaded with FLUSH_SLOTS.
- IDLE, jr_req, N > 0:
  - stall_front = 1 this cycle, combinational.
  - Stall counter loaded with N-1. Next state STALL if N-1 > 0, else remain in IDLE to re-evaluate.
- STALL: stall_front = 1. Counter decrements. When counter == 1, next state is IDLE, where the JR re-evaluates against the now-advanced pipeline.
- FLUSH: flush_ifid = 1, stall_front = 0. Decrement. Return to IDLE after FLUSH_SLOTS cycles.
- A jr_req arriving while in FLUSH is ignored, since that instruction is being squashed.
- fwd_sel is valid only when jr_take = 1 and is 00 otherwise.
- ext_stall = 1:
  - All state, counter and stall_count updates freeze.
  - jr_take and flush_ifid are forced to 0.
  - stall_front and fwd_sel remain driven by the current state.
- stall_count increments when stall_front & !ext_stall and saturates at all-ones.
- busy = (state != IDLE).
- Reset asserted mid-STALL or mid-FLUSH: next cycle is IDLE with all outputs 0. No pending redirect is retained.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with jr_req = 1, rs = 5, ex_hit (load) -> all outputs 0 and state IDLE. After release, the hazard is handled normally.
- ALU forward: jr rs = 8, EX ALU writes r8, MEM writes r8 -> same cycle fwd_sel = 01, jr_take = 1, stall_front = 0. Next cycle flush_ifid = 1 for 1 cycle.
- Load in EX: jr rs = 9, EX load to r9 -> stall_front high 2 cycles, stall_count = 2.
  - Third cycle (load now in WB, no hits): jr_take = 1, fwd_sel = 00.
- Load in MEM: jr rs = 4, MEM load to r4 -> 1 stall cycle, then jr_take with fwd_sel = 00.
  - Variant with an ALU writer to r4 in EX: no stall, fwd_sel = 01.
- r0 / ext_stall: jr rs = 0 with EX load to r0 -> no stall, fwd_sel = 00.
  - Load-stall with ext_stall = 1 for 3 cycles mid-STALL -> stall extended by exactly 3 cycles, stall_count unchanged during the freeze.
- Saturation: with CNT_W = 4, force 20 stall cycles -> stall_count = 15.
